// File: rtl/inv_sbox.sv
// Iterative inverse Ascon S-box layer over a bitsliced 5x64 state, SLICES columns per cycle.
// Optional macro INV_SBOX_SELFCHECK_EN adds a forward-table recheck driving check_err.
module inv_sbox_lane (
  input  logic [4:0] i_v,
  output logic [4:0] o_v
);
  always_comb begin
    o_v = 5'h00;
    case (i_v)
      5'h00: o_v = 5'h14; 5'h01: o_v = 5'h1A; 5'h02: o_v = 5'h07; 5'h03: o_v = 5'h0D;
      5'h04: o_v = 5'h00; 5'h05: o_v = 5'h09; 5'h06: o_v = 5'h0E; 5'h07: o_v = 5'h12;
      5'h08: o_v = 5'h0A; 5'h09: o_v = 5'h06; 5'h0A: o_v = 5'h1D; 5'h0B: o_v = 5'h01;
      5'h0C: o_v = 5'h19; 5'h0D: o_v = 5'h15; 5'h0E: o_v = 5'h13; 5'h0F: o_v = 5'h1E;
      5'h10: o_v = 5'h18; 5'h11: o_v = 5'h16; 5'h12: o_v = 5'h0B; 5'h13: o_v = 5'h11;
      5'h14: o_v = 5'h03; 5'h15: o_v = 5'h05; 5'h16: o_v = 5'h1C; 5'h17: o_v = 5'h1F;
      5'h18: o_v = 5'h17; 5'h19: o_v = 5'h1B; 5'h1A: o_v = 5'h04; 5'h1B: o_v = 5'h08;
      5'h1C: o_v = 5'h0F; 5'h1D: o_v = 5'h0C; 5'h1E: o_v = 5'h10; 5'h1F: o_v = 5'h02;
      default: o_v = 5'h00;
    endcase
  end
endmodule

module inv_sbox #(
  parameter int CWIDTH = 320,
  parameter int SLICES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CWIDTH-1:0] c,
  output logic [CWIDTH-1:0] cout,
  output logic              doneOut,
  output logic              check_err
);
  localparam int W = 64;

  if (CWIDTH != 5*W) begin : g_bad_cwidth
    $error("inv_sbox: CWIDTH must be 320");
  end
  if (SLICES < 1 || SLICES > W || (W % SLICES) != 0) begin : g_bad_slices
    $error("inv_sbox: SLICES must divide 64");
  end

  typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic [CWIDTH-1:0]           r_creg;
  logic [6:0]                  r_col;
  logic                        r_done;
  logic [SLICES-1:0][4:0][8:0] w_bidx;
  logic [SLICES-1:0][4:0]      w_vin;
  logic [SLICES-1:0][4:0]      w_vout;

  // Word k bit (col+s) lands at flat index 64k+col+s; x0 is the column MSB.
  for (genvar s = 0; s < SLICES; s++) begin : g_lane
    for (genvar k = 0; k < 5; k++) begin : g_word
      assign w_bidx[s][k]   = 9'(W*k + s) + {3'b000, r_col[5:0]};
      assign w_vin[s][4-k]  = r_creg[w_bidx[s][k]];
    end
    inv_sbox_lane u_lane (.i_v(w_vin[s]), .o_v(w_vout[s]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_creg  <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: if (en) r_state <= S_INIT;
        S_INIT: begin
          r_creg  <= c;
          r_col   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          for (int s = 0; s < SLICES; s++)
            for (int k = 0; k < 5; k++)
              r_creg[w_bidx[s][k]] <= w_vout[s][4-k];
          r_col <= r_col + 7'(SLICES);
          if (r_col == 7'(W - SLICES)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cout    = r_creg;
  assign doneOut = r_done;

`ifdef INV_SBOX_SELFCHECK_EN
  function automatic logic [4:0] fwd(input logic [4:0] v);
    logic [4:0] t [32];
    t = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
          5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
          5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
          5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    return t[v];
  endfunction

  logic [CWIDTH-1:0] r_shadow;
  logic              r_err;
  logic [SLICES-1:0] w_mis;

  for (genvar s = 0; s < SLICES; s++) begin : g_chk
    logic [4:0] w_orig;
    for (genvar k = 0; k < 5; k++) begin : g_word
      assign w_orig[4-k] = r_shadow[w_bidx[s][k]];
    end
    assign w_mis[s] = (fwd(w_vout[s]) != w_orig);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_shadow <= c;
      if (r_state == S_RUN && |w_mis) r_err <= 1'b1;
    end
  end

  assign check_err = r_err;
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_inv_sbox.sv
// Directed bench for inv_sbox at SLICES=8 (default), 1 and 64 sharing one stimulus stream.
module tb_inv_sbox;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [319:0] c = '0;
  logic [319:0] cout8, cout1, cout64;
  logic         done8, done1, done64;
  logic         err8, err1, err64;

  int n_cmp = 0;
  int n_bad = 0;
  int lat8, lat1, lat64;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO = 64'h0;

  always #5 clk = ~clk;

  inv_sbox #(.CWIDTH(320), .SLICES(8)) dut (
    .clk(clk), .reset(reset), .en(en), .c(c),
    .cout(cout8), .doneOut(done8), .check_err(err8));
  inv_sbox #(.CWIDTH(320), .SLICES(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .c(c),
    .cout(cout1), .doneOut(done1), .check_err(err1));
  inv_sbox #(.CWIDTH(320), .SLICES(64)) dut64 (
    .clk(clk), .reset(reset), .en(en), .c(c),
    .cout(cout64), .doneOut(done64), .check_err(err64));

  // Forward Ascon S-box, used only to build inputs for the round-trip test.
  function automatic logic [319:0] fwd_layer(input logic [319:0] s);
    logic [4:0] t [32];
    logic [319:0] r;
    logic [4:0] v, o;
    t = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
          5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
          5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
          5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    r = '0;
    for (int j = 0; j < 64; j++) begin
      v = {s[j], s[64+j], s[128+j], s[192+j], s[256+j]};
      o = t[v];
      r[j] = o[4]; r[64+j] = o[3]; r[128+j] = o[2]; r[192+j] = o[1]; r[256+j] = o[0];
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; en = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  // Starts one operation and records the first edge (counted from en) where each doneOut is seen.
  task automatic run_op(input logic [319:0] cv, input bit hold_en);
    do_reset();
    @(negedge clk); c = cv; en = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold_en) en = 1'b0;
    lat8 = 0; lat1 = 0; lat64 = 0;
    for (int e = 1; e <= 72; e++) begin
      @(posedge clk); #1;
      if (e == 1) c = ~cv;
      if (done8  && lat8  == 0) lat8  = e;
      if (done1  && lat1  == 0) lat1  = e;
      if (done64 && lat64 == 0) lat64 = e;
    end
    @(negedge clk); en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_cmp++; if ({done8, done1, done64} !== 3'b000) begin n_bad++; $display("FAIL reset_done got %b exp 000", {done8, done1, done64}); end
    n_cmp++; if (cout8 !== 320'h0) begin n_bad++; $display("FAIL reset_cout got %h exp 0", cout8); end
    n_cmp++; if ({err8, err1, err64} !== 3'b000) begin n_bad++; $display("FAIL reset_err got %b exp 000", {err8, err1, err64}); end
  endtask

  task automatic test_zero();
    logic [319:0] exp;
    exp = {ZERO, ZERO, ONES, ZERO, ONES};
    run_op(320'h0, 1'b0);
    n_cmp++; if (lat8  !== 9)  begin n_bad++; $display("FAIL zero_lat8 got %0d exp 9", lat8); end
    n_cmp++; if (lat1  !== 65) begin n_bad++; $display("FAIL zero_lat1 got %0d exp 65", lat1); end
    n_cmp++; if (lat64 !== 2)  begin n_bad++; $display("FAIL zero_lat64 got %0d exp 2", lat64); end
    n_cmp++; if (cout8  !== exp) begin n_bad++; $display("FAIL zero_cout8 got %h exp %h", cout8, exp); end
    n_cmp++; if (cout1  !== exp) begin n_bad++; $display("FAIL zero_cout1 got %h exp %h", cout1, exp); end
    n_cmp++; if (cout64 !== exp) begin n_bad++; $display("FAIL zero_cout64 got %h exp %h", cout64, exp); end
  endtask

  task automatic test_ones_hold_en();
    logic [319:0] exp;
    exp = {ZERO, ONES, ZERO, ZERO, ZERO};
    run_op({5{ONES}}, 1'b1);
    n_cmp++; if (lat8 !== 9) begin n_bad++; $display("FAIL ones_lat8 got %0d exp 9", lat8); end
    n_cmp++; if (cout8 !== exp) begin n_bad++; $display("FAIL ones_cout8 got %h exp %h", cout8, exp); end
    n_cmp++; if (cout1 !== exp) begin n_bad++; $display("FAIL ones_cout1 got %h exp %h", cout1, exp); end
    n_cmp++; if (done8 !== 1'b1) begin n_bad++; $display("FAIL ones_done_sticky got %b exp 1", done8); end
  endtask

  task automatic test_x2_only();
    run_op({ZERO, ZERO, ONES, ZERO, ZERO}, 1'b0);
    n_cmp++; if (cout8 !== 320'h0) begin n_bad++; $display("FAIL x2_cout8 got %h exp 0", cout8); end
    n_cmp++; if (cout64 !== 320'h0) begin n_bad++; $display("FAIL x2_cout64 got %h exp 0", cout64); end
    n_cmp++; if ({err8, err1, err64} !== 3'b000) begin n_bad++; $display("FAIL x2_err got %b exp 000", {err8, err1, err64}); end
  endtask

  task automatic test_roundtrip();
    logic [319:0] orig;
    for (int t = 0; t < 2; t++) begin
      orig = '0;
      for (int w = 0; w < 10; w++) orig[32*w +: 32] = $urandom;
      run_op(fwd_layer(orig), 1'b0);
      n_cmp++; if (cout8  !== orig) begin n_bad++; $display("FAIL rt%0d_cout8 got %h exp %h", t, cout8, orig); end
      n_cmp++; if (cout1  !== orig) begin n_bad++; $display("FAIL rt%0d_cout1 got %h exp %h", t, cout1, orig); end
      n_cmp++; if (cout64 !== orig) begin n_bad++; $display("FAIL rt%0d_cout64 got %h exp %h", t, cout64, orig); end
      n_cmp++; if ({err8, err1, err64} !== 3'b000) begin n_bad++; $display("FAIL rt%0d_err got %b exp 000", t, {err8, err1, err64}); end
    end
  endtask

  task automatic test_mid_reset();
    logic [319:0] exp;
    exp = {ZERO, ZERO, ONES, ZERO, ONES};
    do_reset();
    @(negedge clk); c = {5{ONES}}; en = 1'b1;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({done8, done1, done64} !== 3'b000) begin n_bad++; $display("FAIL midrst_done got %b exp 000", {done8, done1, done64}); end
    n_cmp++; if (cout8 !== 320'h0) begin n_bad++; $display("FAIL midrst_cout8 got %h exp 0", cout8); end
    n_cmp++; if (cout64 !== 320'h0) begin n_bad++; $display("FAIL midrst_cout64 got %h exp 0", cout64); end
    run_op(320'h0, 1'b0);
    n_cmp++; if (lat8 !== 9) begin n_bad++; $display("FAIL midrst_lat8 got %0d exp 9", lat8); end
    n_cmp++; if (cout8 !== exp) begin n_bad++; $display("FAIL midrst_cout8_rerun got %h exp %h", cout8, exp); end
  endtask

`ifdef INV_SBOX_SELFCHECK_EN
  task automatic test_selfcheck();
    do_reset();
    @(negedge clk); c = 320'h0; en = 1'b1;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    force dut.r_shadow = 320'h1;
    @(posedge clk); #1;
    n_cmp++; if (err8 !== 1'b1) begin n_bad++; $display("FAIL selfchk_first got %b exp 1", err8); end
    repeat (10) @(posedge clk); #1;
    n_cmp++; if ({done8, err8} !== 2'b11) begin n_bad++; $display("FAIL selfchk_done got %b exp 11", {done8, err8}); end
    release dut.r_shadow;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_ones_hold_en();
    test_x2_only();
    test_roundtrip();
    test_mid_reset();
`ifdef INV_SBOX_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
